// File: rtl/cr16_pkg.sv
// rtl/cr16_pkg.sv - shared CR16 datapath constants, types and ALU opcodes
package cr16_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int IMM_W    = 8;
  localparam int NUM_REGS = 16;
  localparam int FLAG_W   = 5;

  // PSR bit positions, packed as {L,C,F,Z,N}
  localparam int FLAG_L = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IMM_W-1:0]  imm_t;
  typedef logic [FLAG_W-1:0] flags_t;

  // ALU operations, shared by the decoder and the ALU
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_ADDC = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SUBC = 4'h3,
    ALU_CMP  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_XOR  = 4'h7,
    ALU_MOV  = 4'h8,
    ALU_LSH  = 4'h9,
    ALU_ASH  = 4'hA,
    ALU_NOP  = 4'hF
  } alu_op_e;

endpackage

// File: rtl/cr16_operand_stage_if.sv
// rtl/cr16_operand_stage_if.sv - issue, write-back and operand signals of the operand stage
interface cr16_operand_stage_if;
  import cr16_pkg::*;

  // issue side
  logic   issue_valid;
  logic   stall;
  addr_t  rdest_addr;
  addr_t  rsrc_addr;
  imm_t   imm;
  logic   imm_sel;
  logic   imm_sign;

  // write-back side
  logic   wb_en;
  addr_t  wb_addr;
  word_t  wb_data;
  flags_t flags_in;
  flags_t flags_we;

  // operand / status outputs
  word_t  op_a;
  word_t  op_b;
  logic   op_valid;
  flags_t psr;

  // controller side
  modport master (
    output issue_valid, stall, rdest_addr, rsrc_addr, imm, imm_sel, imm_sign,
    output wb_en, wb_addr, wb_data, flags_in, flags_we,
    input  op_a, op_b, op_valid, psr
  );

  // operand stage side
  modport slave (
    input  issue_valid, stall, rdest_addr, rsrc_addr, imm, imm_sel, imm_sign,
    input  wb_en, wb_addr, wb_data, flags_in, flags_we,
    output op_a, op_b, op_valid, psr
  );

endinterface

// File: rtl/cr16_regbank.sv
// rtl/cr16_regbank.sv - 16x16 general register array, one write port, two async read ports
module cr16_regbank
  import cr16_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  addr_t raddr_a,
  output word_t rdata_a,
  input  addr_t raddr_b,
  output word_t rdata_b
);

  word_t mem [NUM_REGS];

  // storage: whole array cleared on reset, single write port otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // two independent combinational read ports of the stored values
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/cr16_operand_stage.sv
// rtl/cr16_operand_stage.sv - CR16 operand fetch, write-back forwarding and PSR
module cr16_operand_stage
  import cr16_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cr16_operand_stage_if.slave  bus
);

  word_t  stored_a;
  word_t  stored_b;
  word_t  fwd_a;
  word_t  fwd_b;
  word_t  imm_ext;
  word_t  sel_b;

  word_t  op_a_q;
  word_t  op_b_q;
  logic   op_valid_q;
  flags_t psr_q;

  cr16_regbank u_regbank (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (bus.rdest_addr),
    .rdata_a (stored_a),
    .raddr_b (bus.rsrc_addr),
    .rdata_b (stored_b)
  );

  // bypass a same-cycle write-back onto each register read, then pick B source;
  // the immediate path is never bypassed
  always_comb begin
    fwd_a = stored_a;
    fwd_b = stored_b;
    if (bus.wb_en && (bus.wb_addr == bus.rdest_addr)) begin
      fwd_a = bus.wb_data;
    end
    if (bus.wb_en && (bus.wb_addr == bus.rsrc_addr)) begin
      fwd_b = bus.wb_data;
    end
    if (bus.imm_sign) begin
      imm_ext = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    end else begin
      imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
    end
    sel_b = bus.imm_sel ? imm_ext : fwd_b;
  end

  // operand registers: stall freezes everything, otherwise capture on issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      op_valid_q <= bus.issue_valid;
      if (bus.issue_valid) begin
        op_a_q <= fwd_a;
        op_b_q <= sel_b;
      end
    end
  end

  // PSR: per-bit masked write, independent of stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr_q <= '0;
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (bus.flags_we[i]) begin
          psr_q[i] <= bus.flags_in[i];
        end
      end
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_valid = op_valid_q;
  assign bus.psr      = psr_q;

endmodule

// File: tb/tb_cr16_operand_stage.sv
// tb/tb_cr16_operand_stage.sv - self-checking bench for cr16_operand_stage
module tb_cr16_operand_stage;
  import cr16_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cr16_operand_stage_if bus ();

  cr16_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic        st;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm;
    logic        isel;
    logic        isgn;
    logic        wen;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [4:0]  fin;
    logic [4:0]  fwe;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ev;
    logic [4:0]  ep;
  } vec_t;

  vec_t vecs [15];

  // reference state
  logic [15:0] m_regs [16];
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_v;
  logic [4:0]  m_psr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.rdest_addr  = 4'h0;
    bus.rsrc_addr   = 4'h0;
    bus.imm         = 8'h00;
    bus.imm_sel     = 1'b0;
    bus.imm_sign    = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = 4'h0;
    bus.wb_data     = 16'h0000;
    bus.flags_in    = 5'b00000;
    bus.flags_we    = 5'b00000;
  endtask

  task automatic apply(input vec_t v);
    bus.issue_valid = v.iv;
    bus.stall       = v.st;
    bus.rdest_addr  = v.rd;
    bus.rsrc_addr   = v.rs;
    bus.imm         = v.imm;
    bus.imm_sel     = v.isel;
    bus.imm_sign    = v.isgn;
    bus.wb_en       = v.wen;
    bus.wb_addr     = v.wa;
    bus.wb_data     = v.wd;
    bus.flags_in    = v.fin;
    bus.flags_we    = v.fwe;
  endtask

  // what the stage must hold after the coming edge, from the architectural rules
  task automatic model_edge();
    logic [15:0] a_in;
    logic [15:0] b_in;
    a_in = (bus.wb_en && bus.wb_addr == bus.rdest_addr) ? bus.wb_data : m_regs[bus.rdest_addr];
    if (bus.imm_sel)
      b_in = bus.imm_sign ? 16'($signed(bus.imm)) : 16'(bus.imm);
    else
      b_in = (bus.wb_en && bus.wb_addr == bus.rsrc_addr) ? bus.wb_data : m_regs[bus.rsrc_addr];
    if (!bus.stall) begin
      m_v = bus.issue_valid;
      if (bus.issue_valid) begin
        m_a = a_in;
        m_b = b_in;
      end
    end
    m_psr = (m_psr & ~bus.flags_we) | (bus.flags_in & bus.flags_we);
    if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_a   = 16'h0000;
    m_b   = 16'h0000;
    m_v   = 1'b0;
    m_psr = 5'b00000;
  endtask

  initial begin
    //          iv    st    rd     rs     imm     isel  isgn  wen   wa     wd        fin       fwe       ea        eb        ev    ep
    vecs[0]  = '{1'b1, 1'b0, 4'd3,  4'd5,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 1'b1, 5'b00000};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 4'd4,  16'h1234, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 1'b0, 5'b00000};
    vecs[2]  = '{1'b1, 1'b0, 4'd4,  4'd0,  8'hF0, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 5'b00000, 5'b00000, 16'h1234, 16'hFFF0, 1'b1, 5'b00000};
    vecs[3]  = '{1'b1, 1'b0, 4'd4,  4'd0,  8'hF0, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b00000, 5'b00000, 16'h1234, 16'h00F0, 1'b1, 5'b00000};
    vecs[4]  = '{1'b1, 1'b0, 4'd7,  4'd7,  8'h00, 1'b0, 1'b0, 1'b1, 4'd7,  16'hBEEF, 5'b00000, 5'b00000, 16'hBEEF, 16'hBEEF, 1'b1, 5'b00000};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b11111, 5'b01000, 16'hBEEF, 16'hBEEF, 1'b0, 5'b01000};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b00011, 5'b00011, 16'hBEEF, 16'hBEEF, 1'b0, 5'b01011};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 4'd1,  16'h0011, 5'b00000, 5'b00000, 16'hBEEF, 16'hBEEF, 1'b0, 5'b01011};
    vecs[8]  = '{1'b1, 1'b0, 4'd1,  4'd1,  8'h00, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0022, 5'b00000, 5'b00000, 16'h0011, 16'h0011, 1'b1, 5'b01011};
    vecs[9]  = '{1'b1, 1'b1, 4'd2,  4'd2,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b10000, 5'b10000, 16'h0011, 16'h0011, 1'b1, 5'b11011};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 5'b00000, 5'b00000, 16'h0011, 16'h0011, 1'b0, 5'b11011};
    vecs[11] = '{1'b1, 1'b0, 4'd9,  4'd4,  8'h00, 1'b0, 1'b0, 1'b1, 4'd9,  16'h5A5A, 5'b00000, 5'b00000, 16'h5A5A, 16'h1234, 1'b1, 5'b11011};
    vecs[12] = '{1'b1, 1'b0, 4'd3,  4'd4,  8'h00, 1'b0, 1'b0, 1'b1, 4'd4,  16'h7777, 5'b00000, 5'b00000, 16'h0000, 16'h7777, 1'b1, 5'b11011};
    vecs[13] = '{1'b1, 1'b0, 4'd5,  4'd5,  8'h05, 1'b1, 1'b1, 1'b1, 4'd5,  16'hAAAA, 5'b00000, 5'b00000, 16'hAAAA, 16'h0005, 1'b1, 5'b11011};
    vecs[14] = '{1'b1, 1'b0, 4'd15, 4'd0,  8'h7F, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 5'b00000, 5'b00000, 16'h0000, 16'h007F, 1'b1, 5'b11011};

    idle();
    #12;
    chk("reset_op_a", bus.op_a, 16'h0000);
    chk("reset_op_b", bus.op_b, 16'h0000);
    chk("reset_op_valid", 16'(bus.op_valid), 16'h0000);
    chk("reset_psr", 16'(bus.psr), 16'h0000);
    reset = 1'b0;

    // directed table, one clock per record
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_op_a", i), bus.op_a, vecs[i].ea);
      chk($sformatf("vec%0d_op_b", i), bus.op_b, vecs[i].eb);
      chk($sformatf("vec%0d_op_valid", i), 16'(bus.op_valid), 16'(vecs[i].ev));
      chk($sformatf("vec%0d_psr", i), 16'(bus.psr), 16'(vecs[i].ep));
    end

    // async reset mid-cycle with an issue in flight: outputs clear before any edge
    bus.issue_valid = 1'b1;
    bus.rdest_addr  = 4'd9;
    bus.rsrc_addr   = 4'd5;
    #2;
    reset = 1'b1;
    #1;
    chk("async_op_a", bus.op_a, 16'h0000);
    chk("async_op_b", bus.op_b, 16'h0000);
    chk("async_op_valid", 16'(bus.op_valid), 16'h0000);
    chk("async_psr", 16'(bus.psr), 16'h0000);
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // every register reads back zero after reset
    for (int i = 0; i < 16; i++) begin
      bus.issue_valid = 1'b1;
      bus.rdest_addr  = 4'(i);
      bus.rsrc_addr   = 4'(15 - i);
      @(posedge clk);
      #1;
      chk($sformatf("clr_r%0d_a", i), bus.op_a, 16'h0000);
      chk($sformatf("clr_r%0d_b", i), bus.op_b, 16'h0000);
      chk($sformatf("clr_r%0d_v", i), 16'(bus.op_valid), 16'h0001);
    end
    idle();

    // randomized traffic against the reference model
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bus.issue_valid = 1'($urandom_range(0, 3) != 0);
      bus.stall       = 1'($urandom_range(0, 3) == 0);
      bus.rdest_addr  = 4'($urandom);
      bus.rsrc_addr   = 4'($urandom);
      bus.imm         = 8'($urandom);
      bus.imm_sel     = 1'($urandom);
      bus.imm_sign    = 1'($urandom);
      bus.wb_en       = 1'($urandom_range(0, 2) != 0);
      bus.wb_addr     = ($urandom_range(0, 3) == 0) ? bus.rdest_addr : 4'($urandom);
      bus.wb_data     = 16'($urandom);
      bus.flags_in    = 5'($urandom);
      bus.flags_we    = 5'($urandom);
      model_edge();
      @(posedge clk);
      #1;
      chk("rand_op_a", bus.op_a, m_a);
      chk("rand_op_b", bus.op_b, m_b);
      chk("rand_op_valid", 16'(bus.op_valid), 16'(m_v));
      chk("rand_psr", 16'(bus.psr), 16'(m_psr));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
